fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_e             - fetch FSM state encoding
//   DefaultResetPc      - default PC loaded on reset
//   compose_jump_addr() - J-type target: upper nibble of pc+4, index field, word offset
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StValid,
        StError
    } state_e;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    function automatic logic [31:0] compose_jump_addr(input logic [31:0] pc_plus_4,
                                                      input logic [25:0] target);
        return {pc_plus_4[31:28], target, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at pc, holds it for the
// decode stage until it is accepted, then moves to the branch-resolved or jump PC.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   next_pc          next PC from the external branch stage
//   jump/jump_target J-type redirect; overrides next_pc
//   stall            downstream not ready, hold the current instruction
//   imem_req/addr    instruction memory read request and address
//   imem_ready/rdata memory read data valid / data
//   pc, pc_plus_4    current instruction address and its successor
//   instr            captured instruction word
//   instr_valid      instr/pc describe a fetched instruction
//   misaligned       sticky fault: an unaligned next PC was selected
//
// RESET_PC must be word-aligned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] sel_pc;

    assign pc_plus_4 = pc_q + 32'd4;
    assign sel_pc    = jump ? compose_jump_addr(pc_plus_4, jump_target) : next_pc;

    assign pc        = pc_q;
    assign instr     = instr_q;
    // Address is only meaningful while imem_req is high; tying it to pc keeps it
    // stable for the whole request.
    assign imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        misaligned  = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StValid;
                end
            end
            StValid: begin
                instr_valid = 1'b1;
                // next_pc/jump are only looked at on the edge that leaves VALID.
                if (!stall) begin
                    pc_d    = sel_pc;
                    state_d = (sel_pc[1:0] != 2'b00) ? StError : StReq;
                end
            end
            StError: begin
                // Terminal until reset; pc keeps the faulting address for debug.
                misaligned = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] next_pc_drv;
    logic        tie_seq;
    logic        jump;
    logic [25:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] salt;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] model_instr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    assign next_pc    = tie_seq ? pc_plus_4 : next_pc_drv;
    assign imem_rdata = mem_word(imem_addr) ^ salt;

    fetch_unit #(.RESET_PC(RstPc)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .jump       (jump),
        .jump_target(jump_target),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc_plus_4  (pc_plus_4),
        .instr      (instr),
        .instr_valid(instr_valid),
        .misaligned (misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Precondition: DUT is in REQ at address epc. Leaves it in VALID.
    task automatic do_fetch(input int waits, input logic [31:0] epc);
        exp_t e;
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== epc) begin
                errors++;
                $display("FAIL wait_req[%0d]: req=%b addr=%h want req=1 addr=%h",
                         i, imem_req, imem_addr, epc);
            end
            checks++;
            if (instr !== model_instr || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold[%0d]: instr=%h valid=%b want instr=%h valid=0",
                         i, instr, instr_valid, model_instr);
            end
            tick();
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== epc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL req: req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, epc);
        end
        checks++;
        if (pc_plus_4 !== epc + 32'd4) begin
            errors++;
            $display("FAIL pc_plus_4: got %h want %h", pc_plus_4, epc + 32'd4);
        end
        imem_ready = 1'b1;
        sb.push_back('{pc: epc, instr: mem_word(epc) ^ salt});
        tick();
        imem_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL valid: valid=%b req=%b want valid=1 req=0", instr_valid, imem_req);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            model_instr = e.instr;
            checks++;
            if (pc !== e.pc || instr !== e.instr) begin
                errors++;
                $display("FAIL capture: pc=%h instr=%h want pc=%h instr=%h",
                         pc, instr, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_instr = '0;
        checks++;
        if (pc !== RstPc || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            misaligned !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%b valid=%b mis=%b instr=%h want pc=%h 0 0 0 0",
                     pc, imem_req, instr_valid, misaligned, instr, RstPc);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RstPc) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h want req=1 addr=%h",
                     imem_req, imem_addr, RstPc);
        end
    endtask

    task automatic test_sequential();
        tie_seq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, RstPc + 32'(4 * k));
            stall = 1'b0;
            tick();
        end
        tie_seq = 1'b0;
    endtask

    task automatic test_wait();
        do_fetch(3, RstPc + 32'd12);
        next_pc_drv = 32'h1000_0000;
        tick();
    endtask

    task automatic test_jump();
        do_fetch(0, 32'h1000_0000);
        jump        = 1'b1;
        jump_target = 26'h000_0040;
        next_pc_drv = 32'h0000_0003;  // unaligned: must be ignored under jump
        tick();
        jump = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0100 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL jump: req=%b addr=%h mis=%b want req=1 addr=10000100 mis=0",
                     imem_req, imem_addr, misaligned);
        end
    endtask

    task automatic test_stall();
        do_fetch(0, 32'h1000_0100);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_pc_drv = 32'h2000_0000 + 32'(16 * i);
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc !== 32'h1000_0100 || instr !== model_instr ||
                imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b want 1 10000100 %h 0",
                         i, instr_valid, pc, instr, imem_req, model_instr);
            end
        end
        next_pc_drv = 32'h0000_0800;
        stall = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0800) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h want req=1 addr=00000800",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_ready_outside_req();
        do_fetch(0, 32'h0000_0800);
        stall      = 1'b1;
        salt       = 32'hFFFF_0000;
        imem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (instr !== model_instr || instr_valid !== 1'b1 || pc !== 32'h0000_0800) begin
            errors++;
            $display("FAIL ready_ignored: instr=%h valid=%b pc=%h want %h 1 00000800",
                     instr, instr_valid, pc, model_instr);
        end
        imem_ready  = 1'b0;
        salt        = '0;
        next_pc_drv = 32'hFFFF_FFFC;
        stall       = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        checks++;
        if (pc_plus_4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap: pc_plus_4=%h want 00000000", pc_plus_4);
        end
        do_fetch(0, 32'hFFFF_FFFC);
    endtask

    task automatic test_reset_priority();
        next_pc_drv = 32'h0000_0040;
        stall = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        model_instr = '0;
        checks++;
        if (pc !== RstPc || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_over_pc: pc=%h valid=%b req=%b instr=%h want %h 0 0 0",
                     pc, instr_valid, imem_req, instr, RstPc);
        end
        tick();
    endtask

    task automatic test_reset_mid_req();
        imem_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_req: instr=%h valid=%b req=%b want 0 0 0",
                     instr, instr_valid, imem_req);
        end
        tick();  // stale ready seen in IDLE
        imem_ready = 1'b0;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== RstPc) begin
            errors++;
            $display("FAIL stale_ready: instr=%h valid=%b req=%b addr=%h want 0 0 1 %h",
                     instr, instr_valid, imem_req, imem_addr, RstPc);
        end
        do_fetch(1, RstPc);
    endtask

    task automatic test_misaligned();
        next_pc_drv = 32'h0000_0006;
        stall = 1'b0;
        tick();
        next_pc_drv = 32'h0;
        imem_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                pc !== 32'h0000_0006) begin
                errors++;
                $display("FAIL misaligned[%0d]: mis=%b req=%b valid=%b pc=%h want 1 0 0 00000006",
                         i, misaligned, imem_req, instr_valid, pc);
            end
            tick();
        end
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_instr = '0;
        checks++;
        if (misaligned !== 1'b0 || pc !== RstPc) begin
            errors++;
            $display("FAIL mis_clear: mis=%b pc=%h want 0 %h", misaligned, pc, RstPc);
        end
        tick();
        do_fetch(0, RstPc);
    endtask

    initial begin
        rst         = 1'b1;
        next_pc_drv = '0;
        tie_seq     = 1'b0;
        jump        = 1'b0;
        jump_target = '0;
        stall       = 1'b0;
        imem_ready  = 1'b0;
        salt        = '0;
        model_instr = '0;
        tick();
        tick();

        test_reset();
        test_sequential();
        test_wait();
        test_jump();
        test_stall();
        test_ready_outside_req();
        test_wrap();
        test_reset_priority();
        test_reset_mid_req();
        test_misaligned();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
